// File: rtl/rsa_load_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : rsa_load_sequencer
// Description : Host-side feeder for rsa_core. Collects operand bytes from a
//               valid/ready stream, replays each one as a paced load strobe on
//               the core's byte-serial interface, waits for core_done (with a
//               completion timeout) and returns one result byte per operation
//               on a valid/ready result stream.
// Revision    : 1.0 - initial release
// ============================================================================
module rsa_load_sequencer #(
    parameter logic LOAD         = 1'b0,   // active level of core_load
    parameter int   NUM_OPERANDS = 3,      // bytes per operation
    parameter int   LOAD_GAP     = 10,     // idle cycles after every strobe
    parameter int   TIMEOUT      = 65535   // WAIT_DONE budget, 16-bit counter
) (
    input  logic       core_clk,
    input  logic       core_rst,
    input  logic       host_valid,
    output logic       host_ready,
    input  logic [7:0] host_data,
    output logic       res_valid,
    input  logic       res_ready,
    output logic [7:0] res_data,
    output logic       res_err,
    output logic       core_load,
    output logic [7:0] core_din,
    input  logic       core_done,
    input  logic       core_err,
    input  logic [7:0] core_dout
);

    // ------------------------------------------------------------------------
    // Counter widths and terminal values
    // ------------------------------------------------------------------------
    localparam int c_CNT_W = $clog2(NUM_OPERANDS + 1);
    localparam int c_GAP_W = (LOAD_GAP > 1) ? $clog2(LOAD_GAP) : 1;
    localparam int c_TMO_W = 16;

    localparam logic [c_CNT_W-1:0] c_NUM_OPS  = c_CNT_W'(NUM_OPERANDS);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE  = c_CNT_W'(1);
    localparam logic [c_GAP_W-1:0] c_LAST_GAP = c_GAP_W'(LOAD_GAP - 1);
    localparam logic [c_GAP_W-1:0] c_GAP_ONE  = c_GAP_W'(1);
    localparam logic [c_TMO_W-1:0] c_LAST_TMO = c_TMO_W'(TIMEOUT - 1);
    localparam logic [c_TMO_W-1:0] c_TMO_ONE  = c_TMO_W'(1);

    // ------------------------------------------------------------------------
    // Sequencer states
    // ------------------------------------------------------------------------
    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_STROBE    = 3'd1,
        S_GAP       = 3'd2,
        S_WAIT_DONE = 3'd3,
        S_WAIT_LOW  = 3'd4,
        S_RESULT    = 3'd5
    } state_t;

    state_t             state_q,      state_d;
    logic [c_CNT_W-1:0] count_q,      count_d;
    logic [c_GAP_W-1:0] gap_q,        gap_d;
    logic [c_TMO_W-1:0] tmo_q,        tmo_d;
    logic               host_ready_q, host_ready_d;
    logic               res_valid_q,  res_valid_d;
    logic [7:0]         res_data_q,   res_data_d;
    logic               res_err_q,    res_err_d;
    logic               core_load_q,  core_load_d;
    logic [7:0]         core_din_q,   core_din_d;

    logic               w_accept;
    logic               w_res_hs;

    // host_ready is only ever high in IDLE, so the handshake needs no state term
    assign w_accept = host_valid && host_ready_q;
    assign w_res_hs = res_valid_q && res_ready;

    // Next-state, counters and registered-output decode
    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        gap_d       = gap_q;
        tmo_d       = tmo_q;
        res_data_d  = res_data_q;
        res_err_d   = res_err_q;
        core_din_d  = core_din_q;

        case (state_q)
            S_IDLE: begin
                if (w_accept) begin
                    core_din_d = host_data;
                    count_d    = count_q + c_CNT_ONE;
                    state_d    = S_STROBE;
                end
            end

            S_STROBE: begin
                gap_d   = '0;
                state_d = S_GAP;
            end

            S_GAP: begin
                if (gap_q == c_LAST_GAP) begin
                    gap_d = '0;
                    if (count_q < c_NUM_OPS) begin
                        state_d = S_IDLE;
                    end else begin
                        // full operand set delivered: arm the completion timer
                        count_d = '0;
                        tmo_d   = '0;
                        state_d = S_WAIT_DONE;
                    end
                end else begin
                    gap_d = gap_q + c_GAP_ONE;
                end
            end

            S_WAIT_DONE: begin
                if (core_done) begin
                    // done wins over a timeout expiring in the same cycle
                    res_data_d = core_dout;
                    res_err_d  = core_err;
                    state_d    = S_WAIT_LOW;
                end else if (tmo_q == c_LAST_TMO) begin
                    // hung core: report an error and skip the done-low wait
                    res_data_d = 8'h00;
                    res_err_d  = 1'b1;
                    state_d    = S_RESULT;
                end else begin
                    tmo_d = tmo_q + c_TMO_ONE;
                end
            end

            S_WAIT_LOW: begin
                // one capture per done pulse, however long the pulse is
                if (!core_done) begin
                    state_d = S_RESULT;
                end
            end

            S_RESULT: begin
                if (w_res_hs) begin
                    state_d = S_IDLE;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase

        // outputs are registered copies of the decode of the next state
        host_ready_d = (state_d == S_IDLE);
        res_valid_d  = (state_d == S_RESULT);
        core_load_d  = (state_d == S_STROBE) ? LOAD : ~LOAD;
    end

    // State and output registers; reset forces the core interface idle at once
    always_ff @(posedge core_clk or negedge core_rst) begin
        if (!core_rst) begin
            state_q      <= S_IDLE;
            count_q      <= '0;
            gap_q        <= '0;
            tmo_q        <= '0;
            host_ready_q <= 1'b0;
            res_valid_q  <= 1'b0;
            res_data_q   <= 8'h00;
            res_err_q    <= 1'b0;
            core_load_q  <= ~LOAD;
            core_din_q   <= 8'h00;
        end else begin
            state_q      <= state_d;
            count_q      <= count_d;
            gap_q        <= gap_d;
            tmo_q        <= tmo_d;
            host_ready_q <= host_ready_d;
            res_valid_q  <= res_valid_d;
            res_data_q   <= res_data_d;
            res_err_q    <= res_err_d;
            core_load_q  <= core_load_d;
            core_din_q   <= core_din_d;
        end
    end

    assign host_ready = host_ready_q;
    assign res_valid  = res_valid_q;
    assign res_data   = res_data_q;
    assign res_err    = res_err_q;
    assign core_load  = core_load_q;
    assign core_din   = core_din_q;

endmodule
`default_nettype wire

// File: tb/tb_rsa_load_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_rsa_load_sequencer
// Description : Self-checking bench for rsa_load_sequencer. A cycle-stepped
//               reference keeps queues of bytes the host handed over and of
//               results the modelled core will produce, and checks strobes,
//               spacing, result contents and timeout latency against them.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rsa_load_sequencer;

    localparam int c_GAP  = 10;
    localparam int c_TMO  = 100;
    localparam int c_NOPS = 3;
    localparam int c_SPACE = c_GAP + 2;

    logic       clk = 1'b0;
    logic       core_rst;
    logic       host_valid, res_ready, core_done, core_err;
    logic [7:0] host_data, core_dout;
    logic       host_ready, res_valid, res_err, core_load;
    logic [7:0] res_data, core_din;

    always #5 clk = ~clk;

    rsa_load_sequencer #(
        .LOAD         (1'b0),
        .NUM_OPERANDS (c_NOPS),
        .LOAD_GAP     (c_GAP),
        .TIMEOUT      (c_TMO)
    ) dut (
        .core_clk   (clk),
        .core_rst   (core_rst),
        .host_valid (host_valid),
        .host_ready (host_ready),
        .host_data  (host_data),
        .res_valid  (res_valid),
        .res_ready  (res_ready),
        .res_data   (res_data),
        .res_err    (res_err),
        .core_load  (core_load),
        .core_din   (core_din),
        .core_done  (core_done),
        .core_err   (core_err),
        .core_dout  (core_dout)
    );

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;
    int n_results = 0;

    // reference state
    logic [7:0] exp_bytes[$];
    logic [8:0] exp_res[$];          // {err, data}
    bit   accepted = 1'b0;
    int   strobe_idx = 0, last_strobe_cyc = 0, strobe3_cyc = 0;
    bit   prev_load_low = 1'b0, prev_res_valid = 1'b0;
    int   valid_len = 0;
    bit   exact_gap = 1'b0, rr_random = 1'b0, check_len1 = 1'b0, tmo_op = 1'b0;

    // core model configuration (for the next operation) and live state
    logic [7:0] cm_dout, act_dout;
    logic       cm_err, act_err;
    int         cm_delay, cm_width;
    bit         cm_hang = 1'b0, cm_armed = 1'b0;
    int         cm_count = 0, cm_left = 0;

    task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed %0h, expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic set_core(input logic [7:0] d, input logic e, input int dly, input int w, input bit hang);
        cm_dout = d; cm_err = e; cm_delay = dly; cm_width = w; cm_hang = hang;
    endtask

    // One clock: record handshakes seen by the coming edge, then check outputs
    task automatic tick();
        logic [8:0] e;
        accepted = host_valid && host_ready;
        if (accepted) exp_bytes.push_back(host_data);
        if (res_valid && res_ready) begin
            if (exp_res.size() > 0) begin
                e = exp_res.pop_front();
                chk_eq("res_data", 32'(res_data), 32'(e[7:0]));
                chk_eq("res_err", 32'(res_err), 32'(e[8]));
            end
            n_results++;
        end
        @(posedge clk);
        @(negedge clk);
        cyc++;

        // core model: done pulse of cm_width cycles, cm_delay after third strobe
        if (cm_armed) begin
            cm_count--;
            if (cm_count <= 0) begin
                if (cm_left > 0) begin
                    core_done = 1'b1; core_dout = act_dout; core_err = act_err;
                    cm_left--;
                end else begin
                    core_done = 1'b0; cm_armed = 1'b0;
                    core_dout = 8'($urandom); core_err = 1'($urandom);
                end
            end
        end

        // strobe monitor
        if (core_load == 1'b0) begin
            chk_eq("strobe_width", 32'(prev_load_low), 32'd0);
            chk_eq("strobe_pending", 32'(exp_bytes.size() > 0), 32'd1);
            if (exp_bytes.size() > 0) chk_eq("core_din", 32'(core_din), 32'(exp_bytes.pop_front()));
            if (strobe_idx > 0) begin
                if (exact_gap) chk_eq("strobe_spacing", 32'(cyc - last_strobe_cyc), 32'(c_SPACE));
                else           chk_eq("strobe_spacing_min", 32'((cyc - last_strobe_cyc) >= c_SPACE), 32'd1);
            end
            last_strobe_cyc = cyc;
            if (strobe_idx == c_NOPS - 1) begin
                strobe_idx  = 0;
                strobe3_cyc = cyc;
                tmo_op      = cm_hang;
                if (cm_hang) begin
                    exp_res.push_back({1'b1, 8'h00});
                end else begin
                    exp_res.push_back({cm_err, cm_dout});
                    act_dout = cm_dout; act_err = cm_err;
                    cm_armed = 1'b1; cm_count = cm_delay; cm_left = cm_width;
                end
            end else begin
                strobe_idx++;
            end
        end
        prev_load_low = (core_load == 1'b0);

        // result monitor
        if (res_valid) begin
            valid_len++;
            if (!prev_res_valid && tmo_op)
                chk_eq("timeout_latency", 32'(cyc - strobe3_cyc), 32'(c_GAP + 1 + c_TMO));
            chk_eq("result_pending", 32'(exp_res.size() > 0), 32'd1);
            if (exp_res.size() > 0) chk_eq("res_hold", 32'({res_err, res_data}), 32'(exp_res[0]));
        end else begin
            if (prev_res_valid && check_len1) chk_eq("res_valid_len", 32'(valid_len), 32'd1);
            valid_len = 0;
        end
        prev_res_valid = res_valid;
        if (rr_random) res_ready = 1'($urandom_range(0, 1));
    endtask

    task automatic push_byte(input logic [7:0] b);
        host_valid = 1'b1;
        host_data  = b;
        for (int i = 0; i < 300; i++) begin
            tick();
            if (accepted) break;
        end
        chk_eq("accept_seen", 32'(accepted), 32'd1);
    endtask

    task automatic push_triple(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c, input bit jitter);
        logic [7:0] ops [3];
        ops[0] = a; ops[1] = b; ops[2] = c;
        for (int k = 0; k < 3; k++) begin
            if (jitter) begin
                host_valid = 1'b0;
                repeat ($urandom_range(0, 3)) tick();
            end
            push_byte(ops[k]);
        end
        host_valid = 1'b0;
    endtask

    task automatic wait_results(input int target);
        for (int i = 0; i < 400 && n_results < target; i++) tick();
        chk_eq("result_seen", 32'(n_results >= target), 32'd1);
    endtask

    initial begin
        int base;
        host_valid = 1'b0; host_data = 8'h00; res_ready = 1'b0;
        core_done = 1'b0; core_err = 1'b0; core_dout = 8'h00;
        cm_dout = 8'h00; cm_err = 1'b0; cm_delay = 11; cm_width = 1;
        act_dout = 8'h00; act_err = 1'b0;
        core_rst = 1'b1;
        #1 core_rst = 1'b0;

        // reset state
        repeat (5) tick();
        chk_eq("rst_host_ready", 32'(host_ready), 32'd0);
        chk_eq("rst_res_valid", 32'(res_valid), 32'd0);
        chk_eq("rst_res_data", 32'(res_data), 32'h00);
        chk_eq("rst_res_err", 32'(res_err), 32'd0);
        chk_eq("rst_core_load", 32'(core_load), 32'd1);
        chk_eq("rst_core_din", 32'(core_din), 32'h00);
        core_rst = 1'b1;
        chk_eq("release_ready_low", 32'(host_ready), 32'd0);
        tick();
        chk_eq("release_ready_high", 32'(host_ready), 32'd1);
        chk_eq("release_core_load", 32'(core_load), 32'd1);

        // basic operation, back-to-back bytes, immediate result accept
        exact_gap = 1'b1; check_len1 = 1'b1; res_ready = 1'b1;
        set_core(8'h2C, 1'b0, 11, 1, 1'b0);
        push_triple(8'h41, 8'h07, 8'hBB, 1'b0);
        wait_results(n_results + 1);

        // error pass-through; done rises during GAP and is still high on entry
        set_core(8'hFF, 1'b1, 5, 8, 1'b0);
        push_triple(8'h41, 8'h07, 8'hBB, 1'b0);
        wait_results(n_results + 1);
        repeat (3) tick();

        // backpressure: result held for 50 cycles while the host is waiting
        check_len1 = 1'b0; res_ready = 1'b0;
        set_core(8'h5A, 1'b0, 20, 2, 1'b0);
        push_triple(8'h12, 8'h34, 8'h56, 1'b0);
        for (int i = 0; i < 200 && !res_valid; i++) tick();
        chk_eq("bp_valid_seen", 32'(res_valid), 32'd1);
        set_core(8'hC3, 1'b0, 15, 3, 1'b0);
        host_valid = 1'b1; host_data = 8'h33;
        for (int i = 0; i < 50; i++) begin
            tick();
            chk_eq("bp_res_valid", 32'(res_valid), 32'd1);
            chk_eq("bp_host_ready", 32'(host_ready), 32'd0);
        end
        base = n_results;
        res_ready = 1'b1;
        tick();
        chk_eq("bp_one_handshake", 32'(n_results - base), 32'd1);
        chk_eq("bp_valid_drop", 32'(res_valid), 32'd0);
        chk_eq("bp_ready_back", 32'(host_ready), 32'd1);
        push_byte(8'h33);
        push_byte(8'h44);
        push_byte(8'h55);
        host_valid = 1'b0;
        wait_results(n_results + 1);

        // timeout, then a late done pulse that must be ignored
        check_len1 = 1'b1;
        set_core(8'h00, 1'b0, 0, 0, 1'b1);
        push_triple(8'hA1, 8'hA2, 8'hA3, 1'b0);
        wait_results(n_results + 1);
        tmo_op = 1'b0;
        base = n_results;
        repeat (20) tick();
        core_done = 1'b1; core_dout = 8'h99; core_err = 1'b0;
        repeat (3) tick();
        core_done = 1'b0;
        repeat (30) tick();
        chk_eq("late_done_no_result", 32'(n_results - base), 32'd0);
        chk_eq("late_done_idle", 32'(host_ready), 32'd1);

        // reset after two strobes: partial triple discarded
        set_core(8'h77, 1'b0, 12, 1, 1'b0);
        push_byte(8'hD1);
        push_byte(8'hD2);
        host_valid = 1'b0;
        tick();
        chk_eq("mid_two_strobes", 32'(strobe_idx), 32'd2);
        core_rst = 1'b0;
        #1;
        chk_eq("mid_rst_load_async", 32'(core_load), 32'd1);
        exp_bytes.delete();
        strobe_idx = 0;
        repeat (3) tick();
        core_rst = 1'b1;
        base = n_results;
        repeat (100) tick();
        chk_eq("mid_rst_no_result", 32'(n_results - base), 32'd0);
        push_triple(8'hE1, 8'hE2, 8'hE3, 1'b0);
        wait_results(n_results + 1);

        // randomized operations
        exact_gap = 1'b0; check_len1 = 1'b0; rr_random = 1'b1;
        for (int op = 0; op < 8; op++) begin
            set_core(8'($urandom), 1'($urandom), int'($urandom_range(11, 40)),
                     int'($urandom_range(1, 4)), 1'b0);
            push_triple(8'($urandom), 8'($urandom), 8'($urandom), 1'b1);
            wait_results(n_results + 1);
        end
        rr_random = 1'b0;
        repeat (5) tick();
        chk_eq("queues_drained", 32'(exp_bytes.size() + exp_res.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
